// File: rtl/wallace_mult_issue_ctrl_pkg.sv
// Shared widths and helpers for the Wallace multiplier issue/collect wrapper.
package wallace_pkg;

  localparam int unsigned OP_W      = 32;
  localparam int unsigned PROD_W    = 64;
  localparam int unsigned TAG_W_DEF = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// Show-ahead result FIFO with a registered head; pointers wrap at DEPTH (any size).
module mult_result_fifo
  import wallace_pkg::*;
#(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned WIDTH = PROD_W + TAG_W_DEF
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop      = rd_en && (cnt_q != '0);
  assign rd_valid = (cnt_q != '0);
  assign rd_data  = head_q;

  always_comb begin
    rd_d  = pop   ? ptr_inc(rd_q) : rd_q;
    wr_d  = wr_en ? ptr_inc(wr_q) : wr_q;
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CW'(1);
    // Head tracks the entry at rd_d; bypass write data when that slot is being filled now
    head_d = head_q;
    if (cnt_d != '0) head_d = (wr_en && (rd_d == wr_q)) ? wr_data : mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= wr_data;
  end

endmodule

// File: rtl/wallace_mult_issue_ctrl.sv
// Issues handshaked operands into a fixed-latency multiplier and collects products in order;
// a credit counter covering in-flight plus stored results keeps the FIFO from overflowing.
module wallace_mult_issue_ctrl
  import wallace_pkg::*;
#(
  parameter int unsigned MULT_LAT = 8,
  parameter int unsigned DEPTH    = 12,
  parameter int unsigned TAG_W    = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [CW-1:0]           occ_q, occ_d;
  logic [OP_W-1:0]         mul_a_q, mul_b_q;
  logic [MULT_LAT:0]       vpipe_q;
  logic [TAG_W-1:0]        tpipe_q [MULT_LAT+1];
  logic                    accept, pop;
  logic [PROD_W+TAG_W-1:0] fifo_rd;

  assign in_ready = (occ_q < CW'(DEPTH)) && clear_n;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;

  always_comb begin
    occ_d = occ_q;
    if (accept && !pop)      occ_d = occ_q + CW'(1);
    else if (!accept && pop) occ_d = occ_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      occ_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      vpipe_q <= '0;
      for (int unsigned i = 0; i <= MULT_LAT; i++) tpipe_q[i] <= '0;
    end else begin
      occ_q   <= occ_d;
      vpipe_q <= {vpipe_q[MULT_LAT-1:0], accept};
      tpipe_q[0] <= accept ? in_tag : '0;
      for (int unsigned i = 1; i <= MULT_LAT; i++) tpipe_q[i] <= tpipe_q[i-1];
      if (accept) begin
        mul_a_q <= in_a;
        mul_b_q <= in_b;
      end
    end
  end

  mult_result_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(PROD_W + TAG_W)
  ) u_fifo (
    .clk     (clk),
    .clear_n (clear_n),
    .wr_en   (vpipe_q[MULT_LAT]),
    .wr_data ({mul_product, tpipe_q[MULT_LAT]}),
    .rd_en   (out_ready),
    .rd_valid(out_valid),
    .rd_data (fifo_rd)
  );

  assign out_product = fifo_rd[PROD_W+TAG_W-1:TAG_W];
  assign out_tag     = fifo_rd[TAG_W-1:0];

endmodule
